// File: rtl/mult_asm_controller.sv
// rtl/mult_asm_controller.sv - control FSM for the repeated-addition multiplier datapath
//
// Sequences the datapath through load, optional operand swap, a
// decrement/accumulate loop and result commit, then pulses done.
//
// Optional feature macro: MULT_CTRL_ITER_COUNT_EN
//   defined   -> adds iter_count, the number of LOOP cycles of the last multiply
//   undefined -> no iter_count port or counter
//
// Ports:
//   clk         system clock, posedge
//   rst         asynchronous active-high reset
//   start       multiply request, sampled only in IDLE
//   R1          datapath R1 (loop counter operand), unsigned
//   R2          datapath R2 (addend operand), unsigned
//   Enable3     load operands into R1/R2, clear R3 and R
//   Enable7     exchange R1 and R2
//   Enable10    R3 <= R3 + R2, R1 <= R1 - 1
//   Enable9     R4 <= R3, R <= 1
//   busy        high in every state except IDLE
//   done        one-cycle pulse in the cycle after the result commit
//   iter_count  (optional) LOOP cycles counted since the last LOAD

module mult_asm_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    output logic             Enable3,
    output logic             Enable7,
    output logic             Enable10,
    output logic             Enable9,
    output logic             busy,
`ifdef MULT_CTRL_ITER_COUNT_EN
    output logic             done,
    output logic [WIDTH-1:0] iter_count
`else
    output logic             done
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CMP    = 3'd2,
        S_SWAP   = 3'd3,
        S_CHECK  = 3'd4,
        S_LOOP   = 3'd5,
        S_FINISH = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t state;
    state_t next_state;

    // R1/R2 already reflect the enable issued in the previous cycle, so
    // every decision here sees post-update datapath values.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:   next_state = start ? S_LOAD : S_IDLE;
            S_LOAD:   next_state = S_CMP;
            // Keep the smaller operand in the counter to minimise iterations.
            S_CMP:    next_state = (R1 > R2) ? S_SWAP : S_CHECK;
            S_SWAP:   next_state = S_CHECK;
            S_CHECK:  next_state = (R1 == '0) ? S_FINISH : S_LOOP;
            // R1 == 1 means this cycle's decrement is the final one.
            S_LOOP:   next_state = (R1 == WIDTH'(1)) ? S_FINISH : S_LOOP;
            S_FINISH: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they belong to, and clear immediately on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            Enable3  <= 1'b0;
            Enable7  <= 1'b0;
            Enable10 <= 1'b0;
            Enable9  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            Enable3  <= (next_state == S_LOAD);
            Enable7  <= (next_state == S_SWAP);
            Enable10 <= (next_state == S_LOOP);
            Enable9  <= (next_state == S_FINISH);
            busy     <= (next_state != S_IDLE);
            done     <= (next_state == S_DONE);
        end
    end

`ifdef MULT_CTRL_ITER_COUNT_EN
    // Holds through FINISH/DONE/IDLE so software can read it after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_count <= '0;
        end else if (state == S_LOAD) begin
            iter_count <= '0;
        end else if (state == S_LOOP) begin
            iter_count <= iter_count + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mult_asm_controller.sv
// tb/tb_mult_asm_controller.sv - self-checking bench for mult_asm_controller

module tb_mult_asm_controller;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] r1, r2, r3, r4;
    logic [WIDTH-1:0] in1 = '0, in2 = '0;
    logic             Enable3, Enable7, Enable10, Enable9, busy, done;
`ifdef MULT_CTRL_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_count;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mult_asm_controller #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .R1         (r1),
        .R2         (r2),
        .Enable3    (Enable3),
        .Enable7    (Enable7),
        .Enable10   (Enable10),
        .Enable9    (Enable9),
        .busy       (busy),
`ifdef MULT_CTRL_ITER_COUNT_EN
        .done       (done),
        .iter_count (iter_count)
`else
        .done       (done)
`endif
    );

    // Datapath model: acts on an enable at the edge ending its cycle.
    always @(posedge clk) begin
        if (Enable3) begin
            r1 <= in1;
            r2 <= in2;
            r3 <= '0;
        end else if (Enable7) begin
            r1 <= r2;
            r2 <= r1;
        end else if (Enable10) begin
            r3 <= r3 + r2;
            r1 <= r1 - 1;
        end else if (Enable9) begin
            r4 <= r3;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               e7;
        int               e10;
        int               lat;
        logic [WIDTH-1:0] r4;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, n3, n7, n10, n9, ndone, multi, busy_low;
        bit got_done;
        cyc = 0; n3 = 0; n7 = 0; n10 = 0; n9 = 0; ndone = 0; multi = 0; busy_low = 0;
        got_done = 0;
        @(negedge clk);
        in1 = v.a; in2 = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 200) begin
            cyc++;
            n3  += int'(Enable3);
            n7  += int'(Enable7);
            n10 += int'(Enable10);
            n9  += int'(Enable9);
            if ((int'(Enable3) + int'(Enable7) + int'(Enable10) + int'(Enable9)) > 1) multi++;
            if (!busy) busy_low++;
            if (done) begin
                got_done = 1;
                ndone++;
            end else begin
                @(negedge clk);
            end
        end
        check($sformatf("v%0d timeout", idx), got_done, 1);
        check($sformatf("v%0d latency", idx), cyc, v.lat);
        check($sformatf("v%0d enable3_count", idx), n3, 1);
        check($sformatf("v%0d enable7_count", idx), n7, v.e7);
        check($sformatf("v%0d enable10_count", idx), n10, v.e10);
        check($sformatf("v%0d enable9_count", idx), n9, 1);
        check($sformatf("v%0d onehot_violations", idx), multi, 0);
        check($sformatf("v%0d busy_low_cycles", idx), busy_low, 0);
        check($sformatf("v%0d r4", idx), r4, v.r4);
`ifdef MULT_CTRL_ITER_COUNT_EN
        check($sformatf("v%0d iter_count", idx), iter_count, v.e10);
`endif
        @(negedge clk);
        check($sformatf("v%0d idle_busy", idx), busy, 0);
        check($sformatf("v%0d idle_done", idx), done, 0);
    endtask

    initial begin
        int cyc, e3_at[$], done_at[$];
        bit seen;

        vecs[0] = '{32'd3,         32'd5, 0, 3,  8, 32'd15};
        vecs[1] = '{32'd5,         32'd3, 1, 3,  9, 32'd15};
        vecs[2] = '{32'd0,         32'd7, 0, 0,  5, 32'd0};
        vecs[3] = '{32'd7,         32'd0, 1, 0,  6, 32'd0};
        vecs[4] = '{32'd1,         32'd1, 0, 1,  6, 32'd1};
        vecs[5] = '{32'd6,         32'd6, 0, 6, 11, 32'd36};
        vecs[6] = '{32'hFFFF_FFFF, 32'd2, 1, 2,  8, 32'hFFFF_FFFE};
        vecs[7] = '{32'd4,         32'd9, 0, 4,  9, 32'd36};

        // Reset state
        #2;
        check("reset_outputs", {Enable3, Enable7, Enable10, Enable9, busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {Enable3, Enable7, Enable10, Enable9, busy, done}, 0);

        // Asynchronous reset in the middle of LOOP
        in1 = 32'd6; in2 = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Enable10) seen = 1;
            else @(negedge clk);
        end
        check("reach_loop", seen, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_reset_outputs", {Enable3, Enable7, Enable10, Enable9, busy, done}, 0);
`ifdef MULT_CTRL_ITER_COUNT_EN
        check("async_reset_iter", iter_count, 0);
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {Enable3, Enable7, Enable10, Enable9, busy, done}, 0);
        @(negedge clk);
        check("post_reset_stays_idle", {Enable3, busy}, 0);

        // Table-driven multiplies
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

`ifdef MULT_CTRL_ITER_COUNT_EN
        repeat (5) @(negedge clk);
        check("iter_count_hold", iter_count, 4);
`endif

        // start held high: back-to-back multiplies
        @(negedge clk);
        in1 = 32'd2; in2 = 32'd2; start = 1'b1;
        for (cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            if (Enable3) e3_at.push_back(cyc);
            if (done) done_at.push_back(cyc);
            if (cyc == 15) start = 1'b0;
        end
        check("held_e3_total", e3_at.size(), 2);
        check("held_done_total", done_at.size(), 2);
        if (e3_at.size() == 2 && done_at.size() == 2) begin
            check("held_first_e3", e3_at[0], 1);
            check("held_first_done", done_at[0], 7);
            check("held_second_e3", e3_at[1], 9);
            check("held_second_done", done_at[1], 15);
        end
        check("held_r4", r4, 4);
        check("held_idle_end", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
